ncl_th_gate_bank: RTL and testbench

Synchronous, clock-sampled model of the three NCL threshold-gate primitives used by the dual-rail pipeline stages: TH12 (1-of-2 OR), TH22 (2-of-2 C-element with hysteresis) and THnotN (inverting completion gate with initialisation). Each primitive is provided as a WIDTH-lane vector, so one instance covers the data rails, enable and completion logic of a pipeline stage. The block sits between the registered dual-rail datapath and the completion/handshake network.

---
 rtl/ncl_th_gate_bank.sv | 75 +++++++
 tb/tb_ncl_th_gate_bank.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ncl_th_gate_bank.sv
// ncl_th_gate_bank
//   Clock-sampled model of the three NCL threshold-gate primitives used by
//   the dual-rail pipeline stages. Each primitive is a WIDTH-lane vector, so
//   one instance covers the data rails, enable and completion logic of a stage.
//     TH12   : 1-of-2 OR, combinational, ignores init.
//     TH22   : 2-of-2 C-element. Sets on both-high, clears on both-low and
//              holds otherwise. Registered, so output is 1 cycle late.
//     THnotN : inverting completion gate. Registered inversion of its input.
//
//   Optional feature macro: NCL_COMPLETION_EN
//     When defined, this adds th12_all (AND-reduce of th12_z) and th12_none
//     (NOR-reduce of th12_z). Both are combinational.
//
// Ports
//   clk       in   1      sampling clock, rising edge
//   init      in   1      asynchronous active-high init, forces TH22/THnotN state to 0
//   th12_a/b  in   WIDTH  TH12 inputs
//   th12_z    out  WIDTH  TH12 outputs
//   th22_a/b  in   WIDTH  TH22 inputs
//   th22_z    out  WIDTH  TH22 state
//   thn_a     in   WIDTH  THnotN input
//   thn_z     out  WIDTH  THnotN state
//   th12_all  out  1      (NCL_COMPLETION_EN) all th12_z lanes high
//   th12_none out  1      (NCL_COMPLETION_EN) all th12_z lanes low

module ncl_th_gate_bank #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             init,
  input  logic [WIDTH-1:0] th12_a,
  input  logic [WIDTH-1:0] th12_b,
  output logic [WIDTH-1:0] th12_z,
  input  logic [WIDTH-1:0] th22_a,
  input  logic [WIDTH-1:0] th22_b,
  output logic [WIDTH-1:0] th22_z,
  input  logic [WIDTH-1:0] thn_a,
`ifdef NCL_COMPLETION_EN
  output logic [WIDTH-1:0] thn_z,
  output logic             th12_all,
  output logic             th12_none
`else
  output logic [WIDTH-1:0] thn_z
`endif
);

  logic [WIDTH-1:0] th22_s;
  logic [WIDTH-1:0] th22_nxt;
  logic [WIDTH-1:0] thn_s;

  assign th12_z = th12_a | th12_b;

  // The C-element sets when both inputs are high and keeps its value while
  // either input is still high. When the inputs disagree, the state holds.
  assign th22_nxt = (th22_a & th22_b) | (th22_s & (th22_a | th22_b));

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      th22_s <= '0;
      thn_s  <= '0;
    end else begin
      th22_s <= th22_nxt;
      thn_s  <= ~thn_a;
    end
  end

  assign th22_z = th22_s;
  assign thn_z  = thn_s;

`ifdef NCL_COMPLETION_EN
  assign th12_all  = &th12_z;
  assign th12_none = ~|th12_z;
`endif

endmodule

// File: tb/tb_ncl_th_gate_bank.sv
module tb_ncl_th_gate_bank;

  localparam int W = 2;

  logic         clk = 1'b0;
  logic         init;
  logic [W-1:0] th12_a, th12_b, th12_z;
  logic [W-1:0] th22_a, th22_b, th22_z;
  logic [W-1:0] thn_a, thn_z;
`ifdef NCL_COMPLETION_EN
  logic         th12_all, th12_none;
`endif

  int checks = 0;
  int errors = 0;

  // reference state, one entry per lane
  bit m22 [W];
  bit mn  [W];

  always #5 clk = ~clk;

  ncl_th_gate_bank #(.WIDTH(W)) dut (
    .clk(clk), .init(init),
    .th12_a(th12_a), .th12_b(th12_b), .th12_z(th12_z),
    .th22_a(th22_a), .th22_b(th22_b), .th22_z(th22_z),
    .thn_a(thn_a),
`ifdef NCL_COMPLETION_EN
    .thn_z(thn_z),
    .th12_all(th12_all), .th12_none(th12_none)
`else
    .thn_z(thn_z)
`endif
  );

  function automatic void ref_reset();
    for (int i = 0; i < W; i++) begin
      m22[i] = 1'b0;
      mn[i]  = 1'b0;
    end
  endfunction

  // Threshold semantics: count how many TH22 inputs are high per lane.
  function automatic void ref_step();
    int ones;
    for (int i = 0; i < W; i++) begin
      ones = int'(th22_a[i]) + int'(th22_b[i]);
      if (ones == 2) m22[i] = 1'b1;
      else if (ones == 0) m22[i] = 1'b0;
      mn[i] = (thn_a[i] == 1'b0);
    end
  endfunction

  function automatic logic [W-1:0] ref22();
    logic [W-1:0] v;
    for (int i = 0; i < W; i++) v[i] = m22[i];
    return v;
  endfunction

  function automatic logic [W-1:0] refn();
    logic [W-1:0] v;
    for (int i = 0; i < W; i++) v[i] = mn[i];
    return v;
  endfunction

  function automatic logic [W-1:0] ref12();
    logic [W-1:0] v;
    for (int i = 0; i < W; i++) v[i] = (int'(th12_a[i]) + int'(th12_b[i])) >= 1;
    return v;
  endfunction

  // One clock: the model samples at the rising edge, outputs are observed
  // on the following falling edge.
  task automatic tick();
    @(posedge clk);
    if (!init) ref_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    init   = 1'b1;
    th12_a = '1; th12_b = '1;
    th22_a = '1; th22_b = '1;
    thn_a  = '1;
    #1;
    checks++;
    if (th22_z !== 2'b00 || thn_z !== 2'b00) begin
      errors++;
      $display("FAIL reset_immediate: th22_z=%b thn_z=%b, required 00/00", th22_z, thn_z);
    end
    ref_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (th22_z !== 2'b00 || thn_z !== 2'b00 || th12_z !== 2'b11) begin
        errors++;
        $display("FAIL reset_hold[%0d]: th22_z=%b thn_z=%b th12_z=%b, required 00/00/11",
                 c, th22_z, thn_z, th12_z);
      end
    end
    th12_a = '0; th12_b = '0;
    th22_a = '0; th22_b = '0;
    thn_a  = '1;
    init   = 1'b0;
  endtask

  task automatic test_th22_hysteresis();
    th22_a = 2'b11; th22_b = 2'b00;
    tick(); tick();
    checks++;
    if (th22_z !== 2'b00) begin
      errors++; $display("FAIL th22_a1b0: th22_z=%b, required 00", th22_z);
    end
    th22_b = 2'b11;
    tick();
    checks++;
    if (th22_z !== 2'b11) begin
      errors++; $display("FAIL th22_set: th22_z=%b, required 11", th22_z);
    end
    th22_a = 2'b00;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (th22_z !== 2'b11) begin
        errors++; $display("FAIL th22_hold[%0d]: th22_z=%b, required 11", c, th22_z);
      end
    end
    th22_b = 2'b00;
    tick();
    checks++;
    if (th22_z !== 2'b00) begin
      errors++; $display("FAIL th22_clear: th22_z=%b, required 00", th22_z);
    end
    // Inputs swap between disagreeing values, so the state never changes.
    th22_a = 2'b11; th22_b = 2'b00; tick();
    th22_a = 2'b00; th22_b = 2'b11; tick();
    checks++;
    if (th22_z !== 2'b00) begin
      errors++; $display("FAIL th22_toggle: th22_z=%b, required 00", th22_z);
    end
  endtask

  task automatic test_thn();
    logic [W-1:0] seq [4];
    logic [W-1:0] exp [4];
    seq[0] = 2'b00; seq[1] = 2'b11; seq[2] = 2'b11; seq[3] = 2'b00;
    exp[0] = 2'b11; exp[1] = 2'b00; exp[2] = 2'b00; exp[3] = 2'b11;
    for (int k = 0; k < 4; k++) begin
      thn_a = seq[k];
      tick();
      checks++;
      if (thn_z !== exp[k]) begin
        errors++; $display("FAIL thn_seq[%0d]: thn_z=%b, required %b", k, thn_z, exp[k]);
      end
    end
    thn_a = 2'b01;
    tick();
    checks++;
    if (thn_z !== 2'b10) begin
      errors++; $display("FAIL thn_lanes: thn_z=%b, required 10", thn_z);
    end
  endtask

  task automatic test_th12();
    th12_a = 2'b01; th12_b = 2'b10;
    #1;
    checks++;
    if (th12_z !== 2'b11) begin
      errors++; $display("FAIL th12_mixed: th12_z=%b, required 11", th12_z);
    end
    th12_a = 2'b00; th12_b = 2'b00;
    #1;
    checks++;
    if (th12_z !== 2'b00) begin
      errors++; $display("FAIL th12_zero: th12_z=%b, required 00", th12_z);
    end
    th12_a = 2'b00; th12_b = 2'b10;
    #1;
    checks++;
    if (th12_z !== 2'b10) begin
      errors++; $display("FAIL th12_one: th12_z=%b, required 10", th12_z);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    th22_a = 2'b11; th22_b = 2'b11; tick();
    th22_b = 2'b00; tick();
    checks++;
    if (th22_z !== 2'b11) begin
      errors++; $display("FAIL midrst_pre: th22_z=%b, required 11", th22_z);
    end
    #2 init = 1'b1;
    #1;
    checks++;
    if (th22_z !== 2'b00 || thn_z !== 2'b00) begin
      errors++;
      $display("FAIL midrst_async: th22_z=%b thn_z=%b, required 00/00", th22_z, thn_z);
    end
    init = 1'b0;
    ref_reset();
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (th22_z !== 2'b00) begin
        errors++; $display("FAIL midrst_hold[%0d]: th22_z=%b, required 00", c, th22_z);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 60; c++) begin
      th12_a = W'($urandom); th12_b = W'($urandom);
      th22_a = W'($urandom); th22_b = W'($urandom);
      thn_a  = W'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        #2 init = 1'b1;
        #1 init = 1'b0;
        ref_reset();
      end
      #1;
      checks++;
      if (th12_z !== ref12()) begin
        errors++; $display("FAIL rand_th12[%0d]: th12_z=%b, required %b", c, th12_z, ref12());
      end
      tick();
      checks++;
      if (th22_z !== ref22() || thn_z !== refn()) begin
        errors++;
        $display("FAIL rand_state[%0d]: th22_z=%b thn_z=%b, required %b/%b",
                 c, th22_z, thn_z, ref22(), refn());
      end
    end
  endtask

`ifdef NCL_COMPLETION_EN
  task automatic test_completion();
    th12_a = 2'b00; th12_b = 2'b00; #1;
    checks++;
    if (th12_none !== 1'b1 || th12_all !== 1'b0) begin
      errors++; $display("FAIL cmp_zero: all=%b none=%b, required 0/1", th12_all, th12_none);
    end
    th12_a = 2'b01; #1;
    checks++;
    if (th12_none !== 1'b0 || th12_all !== 1'b0) begin
      errors++; $display("FAIL cmp_one: all=%b none=%b, required 0/0", th12_all, th12_none);
    end
    th12_b = 2'b10; #1;
    checks++;
    if (th12_none !== 1'b0 || th12_all !== 1'b1) begin
      errors++; $display("FAIL cmp_full: all=%b none=%b, required 1/0", th12_all, th12_none);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    @(negedge clk);
    tick();
    test_th22_hysteresis();
    test_thn();
    test_th12();
    test_mid_reset();
    test_random();
`ifdef NCL_COMPLETION_EN
    test_completion();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
